// File: rtl/spike_fifo_pkg.sv
// Shared constants and state encoding for the spike-event FIFO controller.
package spike_fifo_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned DEPTH_DEF      = 8;
  localparam int unsigned CNT_W_DEF      = $clog2(DEPTH_DEF + 1);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/spike_fifo_ctrl_if.sv
// Requester, FIFO and consumer signals of the spike FIFO controller.
interface spike_fifo_ctrl_if
  import spike_fifo_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF
);
  localparam int unsigned CNT_W = cnt_width(DEPTH);

  logic [N_REQ-1:0]            req;
  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            ack;
  logic                        fifo_enq;
  logic [DATA_WIDTH-1:0]       fifo_wdata;
  logic                        fifo_deq;
  logic [DATA_WIDTH-1:0]       fifo_rdata;
  logic                        out_valid;
  logic [DATA_WIDTH-1:0]       out_data;
  logic                        out_ready;
  logic                        flush;
  logic                        flush_done;
  logic [CNT_W-1:0]            occupancy;

  modport slave (
    input  req, req_data, fifo_rdata, out_ready, flush,
    output ack, fifo_enq, fifo_wdata, fifo_deq, out_valid, out_data, flush_done, occupancy
  );

  modport master (
    output req, req_data, fifo_rdata, out_ready, flush,
    input  ack, fifo_enq, fifo_wdata, fifo_deq, out_valid, out_data, flush_done, occupancy
  );

endinterface

// File: rtl/spike_fifo_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after rr_ptr wins.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] winner,
  output logic             hit
);

  int unsigned idx;

  always_comb begin
    grant  = '0;
    winner = '0;
    hit    = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % N_REQ;
      if (!hit && req[idx]) begin
        hit    = 1'b1;
        winner = IDX_W'(idx);
      end
    end
    if (en && hit) begin
      grant[winner] = 1'b1;
    end
  end

endmodule

// File: rtl/spike_fifo_ctrl.sv
// Shares one spike-event FIFO between N_REQ requesters with RR write arbitration,
// valid/ready read side and a drain-and-discard flush.
module spike_fifo_ctrl
  import spike_fifo_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF
) (
  input logic              clk,
  input logic              rst_n,
  spike_fifo_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = cnt_width(DEPTH);
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [0:0]            state_q, state_d;
  logic [CNT_W-1:0]      occ_q, occ_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  fifo_enq_q, fifo_enq_d;
  logic [DATA_WIDTH-1:0] fifo_wdata_q, fifo_wdata_d;
  logic                  out_valid_q, out_valid_d;

  logic [N_REQ-1:0]      grant;
  logic [IDX_W-1:0]      winner;
  logic                  hit;
  logic                  grant_any;
  logic                  can_enq;
  logic                  arb_en;
  logic [CNT_W-1:0]      committed;
  logic                  deq_c;
  logic                  flush_done_c;

  // Occupancy counts reserved entries, so the next grant is blocked before the FIFO fills.
  assign can_enq   = occ_q < CNT_W'(DEPTH);
  assign arb_en    = rst_n && (state_q == ST_RUN) && can_enq;
  assign grant_any = |grant;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .en     (arb_en),
    .grant  (grant),
    .winner (winner),
    .hit    (hit)
  );

  // The entry being written at this edge is not readable yet.
  assign committed = occ_q - CNT_W'(fifo_enq_q);
  assign deq_c     = (committed != '0) &&
                     ((state_q == ST_FLUSH) || !out_valid_q || bus.out_ready);

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    fifo_enq_d   = 1'b0;
    fifo_wdata_d = fifo_wdata_q;
    out_valid_d  = out_valid_q;
    flush_done_c = 1'b0;
    occ_d        = occ_q + CNT_W'(grant_any) - CNT_W'(deq_c);
    case (state_q)
      ST_RUN: begin
        if (grant_any) begin
          fifo_enq_d   = 1'b1;
          fifo_wdata_d = bus.req_data[32'(winner)*DATA_WIDTH +: DATA_WIDTH];
          rr_ptr_d     = (32'(winner) == N_REQ - 1) ? '0 : winner + IDX_W'(1);
        end
        out_valid_d = deq_c || (out_valid_q && !bus.out_ready);
        if (bus.flush) begin
          state_d     = ST_FLUSH;
          out_valid_d = 1'b0;
        end
      end
      ST_FLUSH: begin
        out_valid_d = 1'b0;
        if ((occ_q == '0) && !fifo_enq_q) begin
          state_d      = ST_RUN;
          flush_done_c = 1'b1;
        end
      end
      default: begin
        state_d     = ST_RUN;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      occ_q        <= '0;
      rr_ptr_q     <= '0;
      fifo_enq_q   <= 1'b0;
      fifo_wdata_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      occ_q        <= occ_d;
      rr_ptr_q     <= rr_ptr_d;
      fifo_enq_q   <= fifo_enq_d;
      fifo_wdata_q <= fifo_wdata_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign bus.ack        = grant;
  assign bus.fifo_enq   = fifo_enq_q;
  assign bus.fifo_wdata = fifo_wdata_q;
  assign bus.fifo_deq   = deq_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = bus.fifo_rdata;
  assign bus.flush_done = flush_done_c;
  assign bus.occupancy  = occ_q;

endmodule

// File: tb/tb_spike_fifo_ctrl.sv
// Directed self-checking bench for spike_fifo_ctrl with a behavioural FIFO beside it.
module tb_spike_fifo_ctrl;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned DP = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  spike_fifo_ctrl_if #(.N_REQ(NR), .DATA_WIDTH(DW), .DEPTH(DP)) bus ();

  spike_fifo_ctrl #(.N_REQ(NR), .DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Registered-read FIFO model, reset by !rst_n.
  logic [DW-1:0] mem [DP];
  logic [2:0]    wp, rp;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      bus.fifo_rdata <= '0;
    end else begin
      if (bus.fifo_enq) begin
        mem[wp] <= bus.fifo_wdata;
        wp <= wp + 3'd1;
      end
      if (bus.fifo_deq) begin
        bus.fifo_rdata <= mem[rp];
        rp <= rp + 3'd1;
      end
    end
  end

  logic [DW-1:0] pops[$];
  int unsigned   pop_cyc[$];
  int unsigned   cyc = 0;
  int unsigned   deq_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        pops.push_back(bus.out_data);
        pop_cyc.push_back(cyc);
      end
      if (bus.fifo_deq) deq_cnt <= deq_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int i, input logic [DW-1:0] v);
    bus.req_data[i*DW +: DW] = v;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    bus.req = '0;
    bus.out_ready = 1'b1;
    while ((bus.occupancy != '0 || bus.out_valid || bus.fifo_enq) && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, 64'(bus.occupancy != '0 || bus.out_valid), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nxt;
    int got;
    int seen;
    int unsigned deq0;
    logic stall;

    rst_n = 1'b0;
    bus.req = '0;
    bus.req_data = '0;
    bus.out_ready = 1'b0;
    bus.flush = 1'b0;
    #1;
    check("rst_ack",       64'(bus.ack),        64'(0));
    check("rst_fifo_enq",  64'(bus.fifo_enq),   64'(0));
    check("rst_wdata",     64'(bus.fifo_wdata), 64'(0));
    check("rst_out_valid", 64'(bus.out_valid),  64'(0));
    check("rst_flush_done",64'(bus.flush_done), 64'(0));
    check("rst_occupancy", 64'(bus.occupancy),  64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // All four requesters held with fixed data; acks rotate and data flows 1/cycle.
    @(negedge clk);
    for (int i = 0; i < 4; i++) set_word(i, DW'(32'h10 + i));
    bus.req = 4'hF;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      check("rr_ack", 64'(bus.ack), 64'(4'b0001 << (k % 4)));
      if (k == 2) check("rr_no_valid_yet", 64'(bus.out_valid), 64'(0));
      if (k >= 3) begin
        check("rr_out_valid", 64'(bus.out_valid), 64'(1));
        check("rr_out_data",  64'(bus.out_data),  64'(32'h10 + ((k - 3) % 4)));
      end
      @(negedge clk);
    end
    drain("rr_drain");

    // Stream from requester 2 into a stalled consumer until the FIFO is full.
    pops.delete();
    pop_cyc.delete();
    @(negedge clk);
    bus.out_ready = 1'b0;
    nxt = 0;
    set_word(2, 32'hA0);
    bus.req = 4'b0100;
    stall = 1'b0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (bus.ack[2]) begin
        @(negedge clk);
        nxt++;
        set_word(2, DW'(32'hA0 + nxt));
      end else if (bus.occupancy == 4'd8) begin
        stall = 1'b1;
        break;
      end else begin
        @(negedge clk);
      end
    end
    check("full_stalled",   64'(stall),         64'(1));
    check("full_occupancy", 64'(bus.occupancy), 64'(8));
    check("full_ack",       64'(bus.ack),       64'(0));
    check("full_held_valid",64'(bus.out_valid), 64'(1));
    check("full_held_data", 64'(bus.out_data),  64'(32'hA0));
    @(negedge clk);
    #1;
    check("full_still_held",64'(bus.out_data),  64'(32'hA0));

    // Release the consumer at full: pop frees a slot, then grant and pop coincide.
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    check("full_pop_deq",   64'(bus.fifo_deq),  64'(1));
    check("full_pop_noack", 64'(bus.ack),       64'(0));
    @(negedge clk);
    #1;
    check("sim_ack",        64'(bus.ack),       64'(4'b0100));
    check("sim_deq",        64'(bus.fifo_deq),  64'(1));
    check("sim_occ_before", 64'(bus.occupancy), 64'(7));
    @(negedge clk);
    bus.req = '0;
    #1;
    check("sim_occ_after",  64'(bus.occupancy), 64'(7));
    drain("stream_drain");
    check("stream_count", 64'(pops.size()), 64'(10));
    for (int i = 0; i < 10 && i < pops.size(); i++)
      check("stream_order", 64'(pops[i]), 64'(32'hA0 + i));
    if (pop_cyc.size() == 10)
      check("stream_b2b", 64'(pop_cyc[9] - pop_cyc[0]), 64'(9));

    // Single grant into an empty FIFO.
    @(negedge clk);
    set_word(1, 32'h55);
    bus.req = 4'b0010;
    bus.out_ready = 1'b1;
    #1;
    check("one_ack", 64'(bus.ack),      64'(4'b0010));
    check("one_deq0",64'(bus.fifo_deq), 64'(0));
    @(negedge clk);
    bus.req = '0;
    #1;
    check("one_enq",      64'(bus.fifo_enq),   64'(1));
    check("one_wdata",    64'(bus.fifo_wdata), 64'(32'h55));
    check("one_deq_enq",  64'(bus.fifo_deq),   64'(0));
    check("one_occ",      64'(bus.occupancy),  64'(1));
    @(negedge clk);
    #1;
    check("one_deq",      64'(bus.fifo_deq),   64'(1));
    check("one_novalid",  64'(bus.out_valid),  64'(0));
    @(negedge clk);
    #1;
    check("one_valid",    64'(bus.out_valid),  64'(1));
    check("one_data",     64'(bus.out_data),   64'(32'h55));
    @(negedge clk);
    #1;
    check("one_empty_valid", 64'(bus.out_valid), 64'(0));
    check("one_empty_occ",   64'(bus.occupancy), 64'(0));

    // Queue six events (one held at the output, five reserved), then flush.
    @(negedge clk);
    bus.out_ready = 1'b0;
    set_word(0, 32'h30);
    bus.req = 4'b0001;
    got = 0;
    for (int c = 0; c < 30 && got < 6; c++) begin
      #1;
      if (bus.ack[0]) got++;
      @(negedge clk);
      if (got < 6) set_word(0, DW'(32'h30 + got));
    end
    bus.req = '0;
    bus.flush = 1'b1;
    #1;
    check("fl_pre_occ",   64'(bus.occupancy), 64'(5));
    check("fl_pre_valid", 64'(bus.out_valid), 64'(1));
    check("fl_pre_ack",   64'(bus.ack),       64'(0));
    deq0 = deq_cnt;
    pops.delete();
    @(negedge clk);
    bus.flush = 1'b0;
    bus.req = 4'b0001;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      check("fl_ack_gated",  64'(bus.ack),       64'(0));
      check("fl_valid_low",  64'(bus.out_valid), 64'(0));
      if (bus.flush_done) begin
        seen++;
        break;
      end
      @(negedge clk);
    end
    check("fl_done_seen",  64'(seen),             64'(1));
    check("fl_deq_pulses", 64'(deq_cnt - deq0),   64'(5));
    check("fl_occ",        64'(bus.occupancy),    64'(0));
    @(negedge clk);
    #1;
    check("fl_done_pulse", 64'(bus.flush_done),   64'(0));
    check("fl_run_ack",    64'(bus.ack),          64'(4'b0001));
    check("fl_no_pops",    64'(pops.size()),      64'(0));
    drain("fl_drain");

    // Asynchronous reset in the middle of a stream.
    @(negedge clk);
    bus.out_ready = 1'b0;
    set_word(3, 32'h77);
    bus.req = 4'b1000;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus.occupancy == 4'd5) break;
      @(negedge clk);
    end
    check("ar_occ5", 64'(bus.occupancy), 64'(5));
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_ack",       64'(bus.ack),        64'(0));
    check("ar_enq",       64'(bus.fifo_enq),   64'(0));
    check("ar_wdata",     64'(bus.fifo_wdata), 64'(0));
    check("ar_valid",     64'(bus.out_valid),  64'(0));
    check("ar_deq",       64'(bus.fifo_deq),   64'(0));
    check("ar_done",      64'(bus.flush_done), 64'(0));
    check("ar_occ",       64'(bus.occupancy),  64'(0));
    bus.req = 4'hF;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ar_first_ack", 64'(bus.ack),        64'(4'b0001));
    drain("ar_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
